// File: rtl/bp_gshare_pkg.sv
// Shared defaults and entry layout for the gshare branch predictor.
// In-flight entries pack {pc, fail_addr, pred, idx, ghr_before}.
package bp_gshare_pkg;

  localparam int unsigned PC_W         = 32;
  localparam int unsigned IDX_W_DEF    = 6;
  localparam int unsigned CNT_W_DEF    = 2;
  localparam int unsigned HIST_W_DEF   = 6;
  localparam int unsigned Q_W_DEF      = 3;
  localparam int unsigned MODE_BIMODAL = 0;
  localparam int unsigned MODE_GSHARE  = 1;
  localparam int unsigned MODE_DEF     = MODE_GSHARE;

  function automatic int unsigned ent_w(
    input int unsigned idx_w,
    input int unsigned hist_w
  );
    return 2 * PC_W + 1 + idx_w + hist_w;
  endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// Queue of predicted-but-unresolved branches, oldest at the head.
// Flush drops everything and wins over a same-cycle push or pop.
module bp_inflight_fifo #(
  parameter int unsigned Q_W   = 3,
  parameter int unsigned ENT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [ENT_W-1:0] wdata_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [ENT_W-1:0] head_o,
  output logic [Q_W:0]     cnt_o
);

  localparam int DEPTH = 1 << Q_W;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [Q_W-1:0]   wp_q, wp_d;
  logic [Q_W-1:0]   rp_q, rp_d;
  logic [Q_W:0]     cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (Q_W+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rp_q];
  assign cnt_o   = cnt_q;

  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wp_d = wp_q + Q_W'(1);
      if (do_pop)  rp_d = rp_q + Q_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + (Q_W+1)'(1);
        2'b01:   cnt_d = cnt_q - (Q_W+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wp_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/bp_gshare.sv
// Gshare/bimodal conditional-branch predictor with in-order resolve
// from the CDB and history repair on mispredict.
module bp_gshare
  import bp_gshare_pkg::*;
#(
  parameter int unsigned IDX_W  = IDX_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned HIST_W = HIST_W_DEF,
  parameter int unsigned Q_W    = Q_W_DEF,
  parameter int unsigned MODE   = MODE_DEF
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        branch_in,
  input  logic [31:0] imm_in,
  input  logic        inst_len_in,
  input  logic [31:0] pc_in,
  input  logic        cdb_active_in,
  input  logic [31:0] cdb_addr_in,
  input  logic [31:0] cdb_val_in,
  output logic        stall_out,
  output logic        need_branch_out,
  output logic [31:0] branch_addr_out,
  output logic        predict_fail_out,
  output logic [31:0] fail_addr_out,
  output logic [31:0] stat_total_out,
  output logic [31:0] stat_correct_out
);

  localparam int          N  = 1 << IDX_W;
  localparam int unsigned EW = ent_w(IDX_W, HIST_W);
  localparam logic [CNT_W-1:0] CNT_INIT =
    {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]  tbl_q [N];
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic [31:0]       total_q, correct_q;

  logic [IDX_W-1:0]  ghr_ext, idx;
  logic              pred, full, empty;
  logic              accept, resolve, fail, act;
  logic [31:0]       pc_seq, pc_tgt, ent_fail;
  logic [EW-1:0]     ent, head;
  logic [Q_W:0]      q_cnt;

  logic [31:0]       h_pc, h_fail;
  logic              h_pred;
  logic [IDX_W-1:0]  h_idx;
  logic [HIST_W-1:0] h_ghr;
  logic [CNT_W-1:0]  cnt_cur, cnt_nxt;
  logic              unused_val;

  assign unused_val = ^cdb_val_in[31:1];

  assign ghr_ext = (MODE == MODE_GSHARE) ? IDX_W'(ghr_q) : '0;
  assign idx     = pc_in[IDX_W:1] ^ ghr_ext;
  assign pred    = tbl_q[idx][CNT_W-1];

  assign pc_seq   = pc_in + (inst_len_in ? 32'd4 : 32'd2);
  assign pc_tgt   = pc_in + imm_in;
  assign ent_fail = pred ? pc_seq : pc_tgt;
  assign ent      = {pc_in, ent_fail, pred, idx, ghr_q};

  assign h_pc   = head[EW-1 -: PC_W];
  assign h_fail = head[EW-1-PC_W -: PC_W];
  assign h_pred = head[IDX_W+HIST_W];
  assign h_idx  = head[HIST_W +: IDX_W];
  assign h_ghr  = head[HIST_W-1:0];

  assign act     = cdb_val_in[0];
  assign resolve = rdy_in & cdb_active_in & ~empty
                 & (cdb_addr_in == h_pc)
                 & (cdb_addr_in != '0);
  assign fail    = resolve & (h_pred != act);
  assign accept  = branch_in & rdy_in & ~full & ~fail;

  assign stall_out        = branch_in & rdy_in & full;
  assign need_branch_out  = accept & pred;
  assign branch_addr_out  = !accept ? '0
                          : pred ? pc_tgt : pc_seq;
  assign predict_fail_out = fail;
  assign fail_addr_out    = fail ? h_fail : '0;
  assign stat_total_out   = total_q;
  assign stat_correct_out = correct_q;

  always_comb begin
    cnt_cur = tbl_q[h_idx];
    cnt_nxt = cnt_cur;
    if (act) begin
      if (cnt_cur != CNT_MAX) cnt_nxt = cnt_cur + CNT_W'(1);
    end else begin
      if (cnt_cur != '0) cnt_nxt = cnt_cur - CNT_W'(1);
    end
  end

  // Mispredict rebuilds history from the snapshot taken at push time.
  always_comb begin
    ghr_d = ghr_q;
    if (fail)
      ghr_d = {h_ghr[HIST_W-2:0], act};
    else if (accept)
      ghr_d = {ghr_q[HIST_W-2:0], pred};
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ghr_q     <= '0;
      total_q   <= '0;
      correct_q <= '0;
    end else begin
      ghr_q <= ghr_d;
      if (resolve) begin
        total_q <= total_q + 32'd1;
        if (!fail) correct_q <= correct_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < N; i++)
        tbl_q[i] <= CNT_INIT;
    end else if (resolve) begin
      tbl_q[h_idx] <= cnt_nxt;
    end
  end

  bp_inflight_fifo #(
    .Q_W   (Q_W),
    .ENT_W (EW)
  ) u_fifo (
    .clk_i   (clk_in),
    .rst_ni  (rst_n_in),
    .push_i  (accept),
    .pop_i   (resolve & ~fail),
    .flush_i (fail),
    .wdata_i (ent),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head),
    .cnt_o   (q_cnt)
  );

endmodule

// File: tb/tb_bp_gshare.sv
// Directed bench: gshare default instance plus a bimodal Q_W=2 one.
// Both see the same stimulus; each test checks the relevant one.
module tb_bp_gshare;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        br = 1'b0;
  logic        len = 1'b1;
  logic        act = 1'b0;
  logic [31:0] imm = '0;
  logic [31:0] pc = '0;
  logic [31:0] caddr = '0;
  logic [31:0] cval = '0;

  logic        gs_stall, gs_nb, gs_pf;
  logic [31:0] gs_ba, gs_fa, gs_tot, gs_cor;
  logic        bm_stall, bm_nb, bm_pf;
  logic [31:0] bm_ba, bm_fa, bm_tot, bm_cor;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bp_gshare u_gs (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .rdy_in           (rdy),
    .branch_in        (br),
    .imm_in           (imm),
    .inst_len_in      (len),
    .pc_in            (pc),
    .cdb_active_in    (act),
    .cdb_addr_in      (caddr),
    .cdb_val_in       (cval),
    .stall_out        (gs_stall),
    .need_branch_out  (gs_nb),
    .branch_addr_out  (gs_ba),
    .predict_fail_out (gs_pf),
    .fail_addr_out    (gs_fa),
    .stat_total_out   (gs_tot),
    .stat_correct_out (gs_cor)
  );

  bp_gshare #(
    .MODE (0),
    .Q_W  (2)
  ) u_bm (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .rdy_in           (rdy),
    .branch_in        (br),
    .imm_in           (imm),
    .inst_len_in      (len),
    .pc_in            (pc),
    .cdb_active_in    (act),
    .cdb_addr_in      (caddr),
    .cdb_val_in       (cval),
    .stall_out        (bm_stall),
    .need_branch_out  (bm_nb),
    .branch_addr_out  (bm_ba),
    .predict_fail_out (bm_pf),
    .fail_addr_out    (bm_fa),
    .stat_total_out   (bm_tot),
    .stat_correct_out (bm_cor)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    br = 1'b0;
    act = 1'b0;
    caddr = '0;
    cval = '0;
    imm = '0;
    pc = '0;
    len = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic branch(input logic [31:0] p,
                        input logic [31:0] i);
    br = 1'b1;
    pc = p;
    imm = i;
  endtask

  task automatic cdb(input logic [31:0] a,
                     input logic t);
    act = 1'b1;
    caddr = a;
    cval = {31'd0, t};
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    // reset state
    do_reset();
    chk("rst_tot", gs_tot, 0);
    chk("rst_cor", gs_cor, 0);
    chk("rst_nb", gs_nb, 0);
    chk("rst_pf", gs_pf, 0);
    chk("rst_ba", gs_ba, 0);
    chk("rst_ghr", u_gs.ghr_q, 0);
    chk("rst_cnt", u_gs.q_cnt, 0);

    // first branch predicted not taken, resolves taken
    branch(32'h100, 32'h20);
    #1;
    chk("t1_nb", gs_nb, 0);
    chk("t1_ba", gs_ba, 32'h104);
    chk("t1_stall", gs_stall, 0);
    tick();
    br = 1'b0;
    cdb(32'h100, 1'b1);
    #1;
    chk("t1_pf", gs_pf, 1);
    chk("t1_fa", gs_fa, 32'h120);
    tick();
    idle();
    #1;
    chk("t1_ghr", u_gs.ghr_q, 1);
    chk("t1_tot", gs_tot, 1);
    chk("t1_cor", gs_cor, 0);
    chk("t1_cnt", u_gs.q_cnt, 0);

    // 2-byte branch, idx 1, correct not-taken resolve
    branch(32'h100, 32'h20);
    len = 1'b0;
    #1;
    chk("t2_nb", gs_nb, 0);
    chk("t2_ba", gs_ba, 32'h102);
    tick();
    idle();
    #1;
    chk("t2_ghr", u_gs.ghr_q, 2);
    chk("t2_cnt", u_gs.q_cnt, 1);
    cdb(32'h100, 1'b0);
    #1;
    chk("t2_pf", gs_pf, 0);
    chk("t2_fa", gs_fa, 0);
    tick();
    idle();
    #1;
    chk("t2_tot", gs_tot, 2);
    chk("t2_cor", gs_cor, 1);
    chk("t2_cnt", u_gs.q_cnt, 0);

    // bimodal training
    do_reset();
    branch(32'h100, 32'h20);
    #1;
    chk("bm1_nb", bm_nb, 0);
    chk("bm1_ba", bm_ba, 32'h104);
    tick();
    br = 1'b0;
    cdb(32'h100, 1'b1);
    #1;
    chk("bm1_pf", bm_pf, 1);
    tick();
    idle();
    branch(32'h100, 32'h20);
    #1;
    chk("bm2_nb", bm_nb, 1);
    chk("bm2_ba", bm_ba, 32'h120);
    tick();
    br = 1'b0;
    cdb(32'h100, 1'b1);
    #1;
    chk("bm2_pf", bm_pf, 0);
    tick();
    idle();
    branch(32'h100, 32'h20);
    #1;
    chk("bm3_nb", bm_nb, 1);
    chk("bm3_ba", bm_ba, 32'h120);
    chk("bm3_tot", bm_tot, 2);
    chk("bm3_cor", bm_cor, 1);
    tick();
    idle();

    // fill the 4-entry bimodal queue, fifth stalls
    do_reset();
    for (int i = 0; i < 4; i++) begin
      branch(32'h10 * (i + 1), 32'h8);
      #1;
      chk($sformatf("fill%0d_stall", i), bm_stall, 0);
      tick();
    end
    branch(32'h50, 32'h8);
    #1;
    chk("full_stall", bm_stall, 1);
    chk("full_nb", bm_nb, 0);
    chk("full_ba", bm_ba, 0);
    chk("full_cnt", u_bm.q_cnt, 4);
    chk("gs_nostall", gs_stall, 0);
    tick();
    #1;
    chk("full_cnt2", u_bm.q_cnt, 4);
    rdy = 1'b0;
    #1;
    chk("full_rdy0", bm_stall, 0);
    rdy = 1'b1;
    br = 1'b0;
    cdb(32'h10, 1'b0);
    #1;
    chk("full_pf", bm_pf, 0);
    tick();
    idle();
    #1;
    chk("full_pop", u_bm.q_cnt, 3);

    // mispredict flushes three younger entries
    do_reset();
    branch(32'h100, 32'h20);
    tick();
    br = 1'b0;
    cdb(32'h100, 1'b1);
    #1;
    chk("fl_a_pf", gs_pf, 1);
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      branch(32'h100, 32'h20);
      #1;
      chk($sformatf("fl_push%0d", i), gs_nb, 0);
      tick();
    end
    idle();
    #1;
    chk("fl_ghr0", u_gs.ghr_q, 16);
    chk("fl_cnt0", u_gs.q_cnt, 4);
    cdb(32'h100, 1'b1);
    branch(32'h200, 32'h20);
    #1;
    chk("fl_pf", gs_pf, 1);
    chk("fl_fa", gs_fa, 32'h120);
    chk("fl_nb", gs_nb, 0);
    chk("fl_ba", gs_ba, 0);
    tick();
    idle();
    #1;
    chk("fl_cnt", u_gs.q_cnt, 0);
    chk("fl_ghr", u_gs.ghr_q, 3);
    chk("fl_tot", gs_tot, 2);
    chk("fl_cor", gs_cor, 0);

    // correct resolve with simultaneous push
    branch(32'h300, 32'h10);
    #1;
    chk("sc_f_ba", gs_ba, 32'h304);
    tick();
    branch(32'h400, 32'h10);
    cdb(32'h300, 1'b0);
    #1;
    chk("sc_pf", gs_pf, 0);
    chk("sc_ba", gs_ba, 32'h404);
    tick();
    idle();
    #1;
    chk("sc_cnt", u_gs.q_cnt, 1);
    chk("sc_cor", gs_cor, 1);
    chk("sc_tot", gs_tot, 3);
    chk("sc_ghr", u_gs.ghr_q, 12);
    cdb(32'h300, 1'b1);
    #1;
    chk("sc_addr_miss", gs_pf, 0);
    tick();
    #1;
    chk("sc_tot2", gs_tot, 3);

    // rdy low freezes and zeroes outputs
    rdy = 1'b0;
    cdb(32'h400, 1'b1);
    branch(32'h500, 32'h10);
    #1;
    chk("rdy0_pf", gs_pf, 0);
    chk("rdy0_fa", gs_fa, 0);
    chk("rdy0_nb", gs_nb, 0);
    chk("rdy0_ba", gs_ba, 0);
    chk("rdy0_stall", gs_stall, 0);
    tick();
    #1;
    chk("rdy0_tot", gs_tot, 3);
    chk("rdy0_cnt", u_gs.q_cnt, 1);
    rdy = 1'b1;

    // async reset pulse between edges
    br = 1'b0;
    cdb(32'h400, 1'b1);
    #1;
    chk("ar_pre_pf", gs_pf, 1);
    chk("ar_pre_fa", gs_fa, 32'h410);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_pf", gs_pf, 0);
    chk("ar_fa", gs_fa, 0);
    chk("ar_cnt", u_gs.q_cnt, 0);
    chk("ar_ghr", u_gs.ghr_q, 0);
    chk("ar_tot", gs_tot, 0);
    chk("ar_cor", gs_cor, 0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("ar_rel_pf", gs_pf, 0);
    tick();
    chk("ar_rel_pf2", gs_pf, 0);
    act = 1'b0;
    branch(32'h100, 32'h20);
    #1;
    chk("ar_tbl_nb", gs_nb, 0);
    chk("ar_tbl_ba", gs_ba, 32'h104);
    tick();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_gshare.md
BP_GSHARE -- requirements
Module: bp_gshare

Interface
REQ-001 SHALL have parameter IDX_W, default 6, meaning log2 of pattern-table entries.
REQ-002 SHALL have parameter CNT_W, default 2, meaning saturating-counter width (>=2).
REQ-003 SHALL have parameter HIST_W, default 6, meaning global-history width (2..IDX_W).
REQ-004 SHALL have parameter Q_W, default 3, meaning log2 of in-flight queue depth.
REQ-005 SHALL have parameter MODE, default 1, meaning 0 = bimodal, 1 = gshare.
REQ-006 SHALL have port clk_in, input, 1, meaning the single clock; reset is asynchronous and active-low.
REQ-007 SHALL have port rst_n_in, input, 1, meaning asynchronous active-low reset.
REQ-008 SHALL have port rdy_in, input, 1, meaning global enable; low freezes all state.
REQ-009 SHALL have port branch_in, input, 1, meaning the decoded instruction at pc_in is a conditional branch.
REQ-010 SHALL have port imm_in, input, 32, meaning the branch offset.
REQ-011 SHALL have port inst_len_in, input, 1, meaning 1 = 4-byte instruction, 0 = 2-byte instruction.
REQ-012 SHALL have port pc_in, input, 32, meaning the current fetch PC.
REQ-013 SHALL have port cdb_active_in, input, 1, meaning a CDB broadcast is valid.
REQ-014 SHALL have port cdb_addr_in, input, 32, meaning the source PC of the broadcast.
REQ-015 SHALL have port cdb_val_in, input, 32, meaning the broadcast value; bit0 = actual taken.
REQ-016 SHALL have port stall_out, input-to-output combinational, 1, meaning the branch cannot be accepted because the queue is full.
REQ-017 SHALL have port need_branch_out, output, 1, meaning predicted taken.
REQ-018 SHALL have port branch_addr_out, output, 32, meaning the predicted next PC.
REQ-019 SHALL have port predict_fail_out, output, 1, meaning a misprediction was detected.
REQ-020 SHALL have port fail_addr_out, output, 32, meaning the recovery PC.
REQ-021 SHALL have port stat_total_out, output, 32, meaning the count of resolved branches.
REQ-022 SHALL have port stat_correct_out, output, 32, meaning the count of correct predictions.

Function
REQ-023 SHALL compute idx = pc_in[IDX_W:1] XOR zero-extended ghr when MODE=1, and idx = pc_in[IDX_W:1] when MODE=0.
REQ-024 SHALL assert need_branch_out combinationally when accept is true and table[idx] MSB = 1; the outputs of REQ-024 to REQ-026 SHALL be 0 otherwise.
REQ-025 SHALL define accept = branch_in & rdy_in & !full & !predict_fail_out.
REQ-026 SHALL drive branch_addr_out = pc+imm when taken is predicted, else pc+offset (offset 4 or 2); fail_addr is the opposite address; all sums wrap modulo 2^32.
REQ-027 SHALL drive stall_out = branch_in & rdy_in & full, and SHALL NOT halt simulation on overflow.
REQ-028 SHALL, on accept, push {pc, fail_addr, pred, idx, ghr_before} at the tail, and SHALL update ghr to {ghr[HIST_W-2:0], pred} at the next edge.
REQ-029 SHALL define resolve = cdb_active_in & !empty & cdb_addr_in == head.pc & cdb_addr_in != 0.
REQ-030 SHALL drive predict_fail_out = resolve & (head.pred != cdb_val_in[0]), and fail_addr_out = head.fail_addr when it is asserted, else 0.
REQ-031 SHALL, on resolve, saturate table[head.idx] toward the actual outcome (cap at 2^CNT_W-1 or 0); stat_total_out increments, and stat_correct_out increments when the prediction was correct; both wrap modulo 2^32.
REQ-032 SHALL, on resolve without fail, pop the head; a simultaneous accept pushes in the same cycle and occupancy is unchanged.
REQ-033 SHALL, on resolve with fail, empty the queue, set ghr <= {head.ghr_before[HIST_W-2:0], actual}, and suppress the push.
REQ-034 SHALL make a same-cycle prediction and update to one entry use the pre-update counter value.
REQ-035 SHALL track full/empty with a Q_W+1-bit occupancy count; pointers wrap at 2^Q_W, and all 2^Q_W entries are usable.
REQ-036 SHALL, while rdy_in = 0, hold all registers, and all outputs except the stat outputs SHALL be 0.

Reset
REQ-037 SHALL, on rst_n_in low asynchronously, set every counter to 2^(CNT_W-1)-1 (weakly not-taken), ghr = 0, pointers and occupancy = 0, and stats = 0.
REQ-038 SHALL make reset mid-operation discard all in-flight entries, and no predict_fail_out SHALL follow its release.

Structure
REQ-039 SHALL define default parameter values and the entry-field widths in the shared macros file.
REQ-040 SHALL implement the queue as the sub-module bp_inflight_fifo (push, pop, flush, full, empty, head data, parameter Q_W plus entry width).

Verification
REQ-041 SHALL cover: after reset, branch at pc 0x100, imm 0x20 -> need_branch 0, branch_addr 0x104; resolve taken -> predict_fail 1, fail_addr 0x120.
REQ-042 SHALL cover: MODE=0, same branch resolved taken 2 times -> third prediction taken, branch_addr 0x120.
REQ-043 SHALL cover: Q_W=2, 4 unresolved branches -> stall_out 1 on the fifth, with no push and no state change.
REQ-044 SHALL cover: a mispredict with 3 younger entries queued -> queue empty next cycle, ghr = snapshot shifted plus actual bit.
REQ-045 SHALL cover: a correct resolve and a new push in the same cycle -> occupancy unchanged, stat_correct_out +1.
REQ-046 SHALL cover: rst_n_in pulsed low between clock edges with entries queued -> all state reset immediately, and outputs 0.
